// File: rtl/ped_scheduler.sv
// Pedestrian crosswalk scheduler: round-robin service of four crosswalks with timed WALK/FLASH/CLEAR phases.
// Define PED_EMG_PREEMPT_EN to let the emg input preempt service; otherwise emg is ignored.
module ped_scheduler #(
  parameter int unsigned WALK_TIME  = 7,
  parameter int unsigned FLASH_TIME = 5,
  parameter int unsigned CLEAR_TIME = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] ped_req,
  input  logic       safe,
  input  logic       emg,
  output logic       hold_req,
  output logic [3:0] walk,
  output logic [3:0] flash,
  output logic [3:0] pending,
  output logic [1:0] grant_id,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WALK,
    S_FLASH,
    S_CLEAR
  } state_t;

  state_t     state_q;
  logic [4:0] cnt_q;
  logic [1:0] ptr_q;
  logic [1:0] grant_q;
  logic [3:0] pending_q;
  logic [3:0] walk_q;
  logic [3:0] flash_q;
  logic       hold_q;
  logic       err_q;

  logic [3:0] pending_d;
  logic [1:0] next_grant_d;
  logic       preempt;
  logic       walk_go;
  logic       walk_done;
  logic       flash_done;
  logic       clear_done;

`ifdef PED_EMG_PREEMPT_EN
  assign preempt = emg;
`else
  logic emg_unused;
  assign emg_unused = emg;
  assign preempt    = 1'b0;
`endif

  assign walk_go    = (state_q == S_REQ) && safe && !preempt;
  assign walk_done  = tick && (cnt_q == 5'(WALK_TIME - 1));
  assign flash_done = tick && (cnt_q == 5'(FLASH_TIME - 1));
  assign clear_done = tick && (cnt_q == 5'(CLEAR_TIME - 1));

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    next_grant_d = ptr_q + 2'd1;
    pending_d    = pending_q | ped_req;
    // Scan from farthest to nearest so the first set bit after ptr wins.
    for (int k = 4; k >= 1; k--) begin
      if (pending_q[ptr_q + 2'(k)]) next_grant_d = ptr_q + 2'(k);
    end
    if (walk_go) pending_d[grant_q] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      ptr_q     <= 2'd3;
      grant_q   <= 2'd0;
      pending_q <= 4'b0;
      walk_q    <= 4'b0;
      flash_q   <= 4'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= 1'b0;
      if (tick) cnt_q <= cnt_q + 5'd1;
      case (state_q)
        S_IDLE: begin
          if ((pending_q != 4'b0) && !preempt) begin
            state_q <= S_REQ;
            grant_q <= next_grant_d;
            hold_q  <= 1'b1;
            cnt_q   <= 5'd0;
          end
        end
        S_REQ: begin
          if (preempt) begin
            state_q <= S_CLEAR;
            cnt_q   <= 5'd0;
          end else if (safe) begin
            state_q <= S_WALK;
            walk_q  <= 4'b0001 << grant_q;
            ptr_q   <= grant_q;
            cnt_q   <= 5'd0;
          end
        end
        S_WALK: begin
          // A preempt is not a safety fault, so it wins over a safe drop and raises no err.
          if (preempt || !safe) begin
            state_q <= S_CLEAR;
            walk_q  <= 4'b0;
            err_q   <= !preempt;
            cnt_q   <= 5'd0;
          end else if (walk_done) begin
            state_q <= S_FLASH;
            walk_q  <= 4'b0;
            flash_q <= 4'b0001 << grant_q;
            cnt_q   <= 5'd0;
          end
        end
        S_FLASH: begin
          if (preempt || !safe) begin
            state_q <= S_CLEAR;
            flash_q <= 4'b0;
            err_q   <= !preempt;
            cnt_q   <= 5'd0;
          end else if (flash_done) begin
            state_q <= S_CLEAR;
            flash_q <= 4'b0;
            cnt_q   <= 5'd0;
          end
        end
        S_CLEAR: begin
          if (clear_done) begin
            state_q <= S_IDLE;
            hold_q  <= 1'b0;
            cnt_q   <= 5'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          walk_q  <= 4'b0;
          flash_q <= 4'b0;
          hold_q  <= 1'b0;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign hold_req = hold_q;
  assign walk     = walk_q;
  assign flash    = flash_q;
  assign pending  = pending_q;
  assign grant_id = grant_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ped_scheduler.sv
// Self-checking bench for ped_scheduler: a table of per-cycle vectors for the basic service cycle,
// then hand-written sequences for arbitration order, safety abort, request drop, reset and emg.
module tb_ped_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] ped_req;
  logic       safe;
  logic       emg;
  logic       hold_req;
  logic [3:0] walk;
  logic [3:0] flash;
  logic [3:0] pending;
  logic [1:0] grant_id;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ped_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .ped_req (ped_req),
    .safe    (safe),
    .emg     (emg),
    .hold_req(hold_req),
    .walk    (walk),
    .flash   (flash),
    .pending (pending),
    .grant_id(grant_id),
    .err     (err)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic       sf;
    logic       tk;
    logic       hold;
    logic [3:0] walk;
    logic [3:0] flash;
    logic [3:0] pend;
    logic [1:0] gid;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic s, input logic e, input logic t);
    reset   = r;
    ped_req = rq;
    safe    = s;
    emg     = e;
    tick    = t;
  endtask

  task automatic add(input string nm, input logic r, input logic [3:0] rq, input logic s, input logic t,
                     input logic h, input logic [3:0] w, input logic [3:0] f, input logic [3:0] p,
                     input logic [1:0] g, input logic e);
    vec_t v;
    v.name = nm; v.rst = r; v.req = rq; v.sf = s; v.tk = t;
    v.hold = h; v.walk = w; v.flash = f; v.pend = p; v.gid = g; v.err = e;
    vecs.push_back(v);
  endtask

  task automatic wait_walk(input string name, input int budget);
    int n = 0;
    while (walk == 4'b0 && n < budget) begin
      step();
      n++;
    end
    check({name, ".walk_reached"}, 32'(walk != 4'b0), 32'd1);
  endtask

  task automatic wait_flash(input string name, input int budget);
    int n = 0;
    while (flash == 4'b0 && n < budget) begin
      step();
      n++;
    end
    check({name, ".flash_reached"}, 32'(flash != 4'b0), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (hold_req != 1'b0 && n < budget) begin
      step();
      n++;
    end
    check({name, ".idle_reached"}, 32'(hold_req), 32'd0);
  endtask

  initial begin
    drive(1'b1, 4'b0, 1'b1, 1'b0, 1'b0);

    // Basic service of crosswalk 1 with defaults 7/5/2; one tick per row except where noted.
    add("reset",      1, 4'b0000, 1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0);
    add("req_latch",  0, 4'b0010, 1, 0, 0, 4'b0000, 4'b0000, 4'b0010, 2'd0, 0);
    add("enter_req",  0, 4'b0000, 1, 0, 1, 4'b0000, 4'b0000, 4'b0010, 2'd1, 0);
    add("enter_walk", 0, 4'b0000, 1, 1, 1, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0);
    add("walk_t1",    0, 4'b0000, 1, 1, 1, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0);
    add("walk_notick",0, 4'b0000, 1, 0, 1, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0);
    for (int i = 2; i <= 6; i++)
      add($sformatf("walk_t%0d", i), 0, 4'b0000, 1, 1, 1, 4'b0010, 4'b0000, 4'b0000, 2'd1, 0);
    add("walk_t7",    0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0);
    for (int i = 1; i <= 4; i++)
      add($sformatf("flash_t%0d", i), 0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0010, 4'b0000, 2'd1, 0);
    add("flash_t5",   0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0);
    add("clear_t1",   0, 4'b0000, 1, 1, 1, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0);
    add("clear_t2",   0, 4'b0000, 1, 1, 0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].sf, 1'b0, vecs[i].tk);
      step();
      check($sformatf("%s.hold",  vecs[i].name), 32'(hold_req), 32'(vecs[i].hold));
      check($sformatf("%s.walk",  vecs[i].name), 32'(walk),     32'(vecs[i].walk));
      check($sformatf("%s.flash", vecs[i].name), 32'(flash),    32'(vecs[i].flash));
      check($sformatf("%s.pend",  vecs[i].name), 32'(pending),  32'(vecs[i].pend));
      check($sformatf("%s.gid",   vecs[i].name), 32'(grant_id), 32'(vecs[i].gid));
      check($sformatf("%s.err",   vecs[i].name), 32'(err),      32'(vecs[i].err));
    end

    // ptr is now 1: requests 0 and 2 together must serve 2 first, then 0.
    drive(1'b0, 4'b0101, 1'b1, 1'b0, 1'b1);
    step();
    check("rr0101.pend", 32'(pending), 32'h5);
    ped_req = 4'b0;
    wait_walk("rr0101.first", 20);
    check("rr0101.first_gid",  32'(grant_id), 32'd2);
    check("rr0101.first_walk", 32'(walk),     32'h4);
    wait_idle("rr0101.first", 40);
    wait_walk("rr0101.second", 20);
    check("rr0101.second_gid",  32'(grant_id), 32'd0);
    check("rr0101.second_walk", 32'(walk),     32'h1);
    check("rr0101.second_pend", 32'(pending),  32'h0);

    // All four pending from reset: order 0,1,2,3.
    drive(1'b1, 4'b0, 1'b1, 1'b0, 1'b1);
    step();
    drive(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
    step();
    ped_req = 4'b0;
    for (int k = 0; k < 4; k++) begin
      wait_walk($sformatf("rr1111.%0d", k), 20);
      check($sformatf("rr1111.%0d.gid", k),  32'(grant_id), 32'(k));
      check($sformatf("rr1111.%0d.walk", k), 32'(walk),     32'(4'b0001 << k));
      wait_idle($sformatf("rr1111.%0d", k), 40);
    end
    check("rr1111.pend_empty", 32'(pending), 32'h0);

    // REQ has no timeout; safe drop on the 3rd WALK tick aborts to CLEAR with a one-cycle err.
    drive(1'b1, 4'b0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    repeat (20) step();
    check("req_wait.hold", 32'(hold_req), 32'd1);
    check("req_wait.walk", 32'(walk),     32'h0);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    check("abort.walk_on", 32'(walk), 32'h1);
    tick = 1'b1;
    step();
    step();
    check("abort.walk_2ticks", 32'(walk), 32'h1);
    safe = 1'b0;
    step();
    check("abort.walk_off", 32'(walk),     32'h0);
    check("abort.flash",    32'(flash),    32'h0);
    check("abort.err",      32'(err),      32'd1);
    check("abort.hold",     32'(hold_req), 32'd1);
    drive(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    check("abort.err_pulse", 32'(err),      32'd0);
    check("abort.clear_hold", 32'(hold_req), 32'd1);
    tick = 1'b1;
    step();
    check("abort.clear_t1", 32'(hold_req), 32'd1);
    step();
    check("abort.clear_t2", 32'(hold_req), 32'd0);

    // Request on the WALK-entry cycle is dropped; reset mid-FLASH and mid-WALK clears everything.
    drive(1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    step();
    ped_req = 4'b0;
    step();
    check("drop.in_req", 32'(hold_req), 32'd1);
    drive(1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    step();
    check("drop.walk",       32'(walk),    32'h2);
    check("drop.pend_entry", 32'(pending), 32'h0);
    ped_req = 4'b0;
    step();
    check("drop.pend_after", 32'(pending), 32'h0);
    tick = 1'b1;
    wait_flash("rst_flash", 20);
    check("rst_flash.flash", 32'(flash), 32'h2);
    drive(1'b1, 4'b1111, 1'b1, 1'b1, 1'b1);
    step();
    check("rst_flash.hold",  32'(hold_req), 32'd0);
    check("rst_flash.walk",  32'(walk),     32'h0);
    check("rst_flash.flash_off", 32'(flash), 32'h0);
    check("rst_flash.pend",  32'(pending),  32'h0);
    check("rst_flash.gid",   32'(grant_id), 32'd0);
    check("rst_flash.err",   32'(err),      32'd0);
    drive(1'b0, 4'b0100, 1'b1, 1'b0, 1'b0);
    step();
    ped_req = 4'b0;
    wait_walk("rst_walk", 10);
    check("rst_walk.walk_on", 32'(walk), 32'h4);
    reset = 1'b1;
    step();
    check("rst_walk.walk_off", 32'(walk),     32'h0);
    check("rst_walk.hold",     32'(hold_req), 32'd0);

    // Emergency input: preempts when the feature is built in, ignored otherwise.
    drive(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1);
    step();
    ped_req = 4'b0;
    wait_flash("emg", 30);
    emg = 1'b1;
    step();
`ifdef PED_EMG_PREEMPT_EN
    check("emg.flash_off", 32'(flash),    32'h0);
    check("emg.hold",      32'(hold_req), 32'd1);
    check("emg.no_err",    32'(err),      32'd0);
    emg = 1'b0;
    wait_idle("emg.clear", 10);
    drive(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    step();
    ped_req = 4'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("emg.idle_hold%0d", i), 32'(hold_req), 32'd0);
    end
    check("emg.idle_pend", 32'(pending), 32'h1);
    emg = 1'b0;
    step();
    check("emg.release_hold", 32'(hold_req), 32'd1);
    check("emg.release_gid",  32'(grant_id), 32'd0);
`else
    check("emg.ignored_flash", 32'(flash), 32'h1);
    check("emg.ignored_err",   32'(err),   32'd0);
    wait_idle("emg.ignored", 20);
    drive(1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    step();
    ped_req = 4'b0;
    step();
    check("emg.ignored_idle_exit", 32'(hold_req), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ped_scheduler.md
PED_SCHEDULER -- requirements
Module: ped_scheduler

Interface
REQ-001 Parameter WALK_TIME, default 7, walk interval length in tick pulses (legal range 1..31).
REQ-002 Parameter FLASH_TIME, default 5, flashing don't-walk interval in tick pulses (legal range 1..31).
REQ-003 Parameter CLEAR_TIME, default 2, all-stop clearance interval in tick pulses (legal range 1..31).
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 tick  input  1  one-clk-wide timebase enable pulse (1 Hz strobe).
REQ-007 ped_req  input  4  crosswalk button levels, one bit per crosswalk 0..3.
REQ-008 safe  input  1  light controller confirms that all conflicting vehicle lanes are red.
REQ-009 emg  input  1  emergency-vehicle preempt request.
REQ-010 hold_req  output  1  asks the light controller to bring conflicting lanes to red and hold them.
REQ-011 walk  output  4  one-hot WALK lamp for the granted crosswalk.
REQ-012 flash  output  4  one-hot flashing DON'T-WALK lamp for the granted crosswalk.
REQ-013 pending  output  4  latched, unserved requests.
REQ-014 grant_id  output  2  index of the crosswalk currently or most recently served.
REQ-015 err  output  1  one-clk pulse when safe drops during WALK or FLASH.

Function
REQ-016 pending[i] SHALL set on any clk where ped_req[i]=1, and SHALL clear on the cycle its crosswalk enters WALK; a ped_req[i] on that same cycle SHALL be dropped.
REQ-017 The FSM SHALL have exactly five states: IDLE, REQ, WALK, FLASH, CLEAR.
REQ-018 IDLE with pending!=0 -> REQ next cycle: grant_id SHALL be loaded with the first set pending bit found scanning upward from ptr+1, wrapping 3->0.
REQ-019 ptr SHALL be updated to grant_id on WALK entry.
REQ-020 REQ: hold_req=1; go to WALK on the first cycle with safe=1; there is no timeout.
REQ-021 WALK: walk[grant_id]=1 and hold_req=1.
REQ-022 FLASH: flash[grant_id]=1 and hold_req=1.
REQ-023 CLEAR: walk=0, flash=0, hold_req=1; go to IDLE when the CLEAR count ends.
REQ-024 A 5-bit interval counter SHALL clear on every state entry and increment on tick.
REQ-025 State exit from WALK, FLASH and CLEAR SHALL occur on the clk where tick=1 and the counter equals T-1, giving exactly T ticks per interval.
REQ-026 Any safe=0 during WALK or FLASH SHALL force CLEAR next cycle and pulse err for one cycle.
REQ-027 hold_req SHALL be 0 only in IDLE.
REQ-028 walk and flash SHALL never be nonzero simultaneously.
REQ-029 Each of walk and flash SHALL have at most one bit set.
REQ-030 A tick arriving on a state-entry cycle SHALL NOT count toward the new interval.

Reset
REQ-031 On reset=1 at a clk edge: state=IDLE, walk=0, flash=0, hold_req=0, pending=0, grant_id=0, ptr=3, counter=0, err=0.
REQ-032 Reset asserted mid-WALK SHALL extinguish walk on the same edge, with no clearance interval.
REQ-033 Reset SHALL dominate ped_req, safe, emg and tick.

Configuration
REQ-034 Macro PED_EMG_PREEMPT_EN defined: emg=1 in REQ, WALK or FLASH SHALL force CLEAR next cycle.
REQ-035 With PED_EMG_PREEMPT_EN defined, IDLE SHALL NOT leave while emg=1, and pending SHALL be retained; err SHALL NOT pulse on a preempt.
REQ-036 Macro PED_EMG_PREEMPT_EN undefined: emg SHALL be ignored and the port SHALL remain present.

Verification
REQ-037 Reset, then ped_req=0010 for 1 clk, safe=1 -> REQ one clk later, then WALK with walk=0010 for 7 ticks, flash=0010 for 5 ticks, CLEAR for 2 ticks, IDLE with hold_req=0.
REQ-038 pending=1111 from reset -> service order 0,1,2,3; ptr=1 with pending=0101 -> crosswalk 2 served before 0.
REQ-039 safe=0 on the 3rd WALK tick -> CLEAR next clk, err high exactly 1 clk, walk=0.
REQ-040 PED_EMG_PREEMPT_EN defined, emg=1 during FLASH -> CLEAR next clk; an emg held through IDLE with pending=0001 keeps hold_req=0 until emg=0.
REQ-041 ped_req[1]=1 on the WALK-entry cycle of crosswalk 1 -> pending[1]=0 afterward; reset mid-FLASH -> all outputs 0 next edge.
